fir_tap_loader: RTL and testbench

FIR_TAP_LOADER -- requirements
Module: fir_tap_loader

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_tap_loader.sv | 85 ++++++++
 tb/tb_fir_tap_loader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR chain sizing, tile-link structs and loader state encoding
package fir_pkg;
  localparam int FIR_TILE_NUM  = 4;
  localparam int FIR_TAP_WIDTH = 16;
  localparam int FIR_CNT_WIDTH = $clog2(FIR_TILE_NUM + 1);
  typedef struct packed {
    logic                     valid;
    logic [FIR_TAP_WIDTH-1:0] data;
  } FIR_TAP_LOAD;
  typedef struct packed {
    logic clear;
    logic run;
  } FIR_CONT_TO_TILE;
  typedef enum logic [2:0] {LD_IDLE, LD_CLEAR, LD_LOAD, LD_DRAIN, LD_RUN} fir_ld_state_e;
endpackage

// File: rtl/fir_tap_loader.sv
// fir_tap_loader: streams host coefficients into the tile chain, then releases it to run
module fir_tap_loader
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic                     cfg_stop,
  input  logic                     tap_valid,
  input  logic [FIR_TAP_WIDTH-1:0] tap_data,
  output logic                     tap_ready,
  output FIR_TAP_LOAD              tap_out,
  output FIR_CONT_TO_TILE          cont_out,
  output logic                     busy,
  output logic                     done
);
  fir_ld_state_e            state_q, state_d;
  logic [FIR_CNT_WIDTH-1:0] tap_cnt_q, tap_cnt_d;
  logic [FIR_CNT_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
  FIR_TAP_LOAD              tap_q, tap_d;
  logic                     done_q, done_d;
  // next state: stop aborts any load phase, start only acts from IDLE/RUN and beats stop
  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    drain_cnt_d = drain_cnt_q;
    tap_d       = '{valid: 1'b0, data: tap_q.data};
    done_d      = 1'b0;
    case (state_q)
      LD_IDLE:  state_d = cfg_start ? LD_CLEAR : LD_IDLE;
      LD_CLEAR: begin
        tap_cnt_d = '0;
        state_d   = cfg_stop ? LD_IDLE : LD_LOAD;
      end
      LD_LOAD: begin
        if (cfg_stop) begin
          state_d   = LD_IDLE;
          tap_cnt_d = '0;
        end else if (tap_valid) begin
          tap_d     = '{valid: 1'b1, data: tap_data};
          tap_cnt_d = tap_cnt_q + FIR_CNT_WIDTH'(1);
          if (tap_cnt_q == FIR_CNT_WIDTH'(FIR_TILE_NUM - 1)) begin
            state_d     = LD_DRAIN;
            drain_cnt_d = FIR_CNT_WIDTH'(FIR_TILE_NUM - 1);
          end
        end
      end
      LD_DRAIN: begin
        if (cfg_stop) begin
          state_d     = LD_IDLE;
          tap_cnt_d   = '0;
          drain_cnt_d = '0;
        end else if (drain_cnt_q == '0) begin
          state_d = LD_RUN;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - FIR_CNT_WIDTH'(1);
        end
      end
      LD_RUN:  state_d = cfg_start ? LD_CLEAR : cfg_stop ? LD_IDLE : LD_RUN;
      default: state_d = LD_IDLE;
    endcase
  end
  // state, counters and the registered tap path all clear asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LD_IDLE;
      tap_cnt_q   <= '0;
      drain_cnt_q <= '0;
      tap_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      tap_q       <= tap_d;
      done_q      <= done_d;
    end
  end
  assign tap_ready = state_q == LD_LOAD;
  assign busy      = state_q == LD_CLEAR || state_q == LD_LOAD || state_q == LD_DRAIN;
  assign cont_out  = '{clear: state_q == LD_CLEAR, run: state_q == LD_RUN};
  assign tap_out   = tap_q;
  assign done      = done_q;
endmodule

// File: tb/tb_fir_tap_loader.sv
// tb_fir_tap_loader: randomized loads scored against queued tap and done expectations
module tb_fir_tap_loader;
  import fir_pkg::*;
  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     cfg_start = 1'b0;
  logic                     cfg_stop = 1'b0;
  logic                     tap_valid = 1'b0;
  logic [FIR_TAP_WIDTH-1:0] tap_data = '0;
  logic                     tap_ready;
  FIR_TAP_LOAD              tap_out;
  FIR_CONT_TO_TILE          cont_out;
  logic                     busy;
  logic                     done;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [FIR_TAP_WIDTH-1:0] exp_tap[$];
  int                       exp_done[$];
  logic [FIR_TAP_WIDTH-1:0] exp_hold = '0;
  logic [FIR_TAP_WIDTH-1:0] e_tap;
  int                       e_cyc;
  fir_tap_loader dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .tap_valid(tap_valid), .tap_data(tap_data), .tap_ready(tap_ready),
    .tap_out(tap_out), .cont_out(cont_out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", n, a, e, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all_zero(input string n);
    chk({n, "_ready"}, 32'(tap_ready), 0);
    chk({n, "_busy"}, 32'(busy), 0);
    chk({n, "_done"}, 32'(done), 0);
    chk({n, "_clear"}, 32'(cont_out.clear), 0);
    chk({n, "_run"}, 32'(cont_out.run), 0);
    chk({n, "_tvalid"}, 32'(tap_out.valid), 0);
    chk({n, "_tdata"}, 32'(tap_out.data), 0);
  endtask
  // monitor: every presented tap and done pulse is matched against the scoreboard
  initial forever begin
    @(negedge clk);
    chk("clear_run_excl", 32'(cont_out.clear & cont_out.run), 0);
    if (tap_out.valid) begin
      if (exp_tap.size() == 0) chk("tap_unexpected", 1, 0);
      else begin
        e_tap = exp_tap.pop_front();
        chk("tap_data", 32'(tap_out.data), 32'(e_tap));
        exp_hold = e_tap;
      end
    end else chk("tap_hold", 32'(tap_out.data), 32'(exp_hold));
    if (done) begin
      if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e_cyc = exp_done.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e_cyc));
      end
    end
  end
  task automatic do_load(input bit with_stop, input int abort_after, input int lo, input int hi,
                         input bit nominal, input bit rst_drain);
    int h;
    h = 0;
    cfg_start = 1'b1;
    cfg_stop  = with_stop;
    tap_valid = 1'b0;
    tick();
    cfg_start = 1'($urandom_range(0, 1));
    cfg_stop  = 1'b0;
    tap_valid = 1'b1;
    tap_data  = 16'($urandom);
    chk("clr_clear", 32'(cont_out.clear), 1);
    chk("clr_run", 32'(cont_out.run), 0);
    chk("clr_ready", 32'(tap_ready), 0);
    chk("clr_busy", 32'(busy), 1);
    tick();
    for (int i = 0; i < FIR_TILE_NUM; i++) begin
      if (i == abort_after) begin
        cfg_start = 1'b0;
        tap_valid = 1'b0;
        cfg_stop  = 1'b1;
        chk("abort_ready_pre", 32'(tap_ready), 1);
        tick();
        cfg_stop = 1'b0;
        chk("abort_ready", 32'(tap_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_run", 32'(cont_out.run), 0);
        chk("abort_done", 32'(done), 0);
        return;
      end
      repeat ($urandom_range(lo, hi)) begin
        cfg_start = ($urandom_range(0, 3) == 0);
        tap_valid = 1'b0;
        tap_data  = 16'($urandom);
        chk("gap_ready", 32'(tap_ready), 1);
        tick();
      end
      cfg_start = 1'b0;
      tap_valid = 1'b1;
      tap_data  = nominal ? 16'(FIR_TILE_NUM - i) : 16'($urandom);
      exp_tap.push_back(tap_data);
      chk("tap_ready", 32'(tap_ready), 1);
      h = cyc;
      tick();
    end
    exp_done.push_back(h + FIR_TILE_NUM + 1);
    for (int d = 1; d <= FIR_TILE_NUM; d++) begin
      cfg_start = 1'($urandom_range(0, 1));
      tap_valid = 1'($urandom_range(0, 1));
      tap_data  = 16'($urandom);
      chk("drain_busy", 32'(busy), 1);
      chk("drain_ready", 32'(tap_ready), 0);
      chk("drain_run", 32'(cont_out.run), 0);
      if (rst_drain && d == 2) begin
        #2;
        rst = 1'b1;
        exp_hold = '0;
        exp_done.delete();
        cfg_start = 1'b0;
        tap_valid = 1'b0;
        #1;
        chk_all_zero("rst_drain");
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        return;
      end
      tick();
    end
    cfg_start = 1'b0;
    tap_valid = 1'b0;
    chk("run_run", 32'(cont_out.run), 1);
    chk("run_busy", 32'(busy), 0);
    chk("run_clear", 32'(cont_out.clear), 0);
  endtask
  task automatic stop_run();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    chk("stop_run", 32'(cont_out.run), 0);
    chk("stop_busy", 32'(busy), 0);
  endtask
  initial begin
    #2;
    chk_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all_zero("post_reset");
    do_load(0, -1, 0, 0, 1, 0);
    stop_run();
    do_load(0, -1, 1, 1, 1, 0);
    do_load(0, -1, 0, 2, 0, 0);
    do_load(1, -1, 0, 2, 0, 0);
    stop_run();
    do_load(0, 2, 0, 1, 0, 0);
    do_load(0, -1, 0, 2, 0, 0);
    do_load(0, 0, 0, 0, 0, 0);
    do_load(0, -1, 0, 2, 0, 1);
    do_load(0, -1, 0, 2, 0, 0);
    for (int k = 0; k < 8; k++) begin
      do_load($urandom_range(0, 1), $urandom_range(0, 1) ? -1 : int'($urandom_range(0, FIR_TILE_NUM - 1)),
              0, 3, 0, 0);
      if ($urandom_range(0, 1)) begin
        if (cont_out.run) stop_run();
      end
      if (!cont_out.run) do_load(0, -1, 0, 2, 0, 0);
    end
    repeat (6) tick();
    chk("taps_left", 32'(exp_tap.size()), 0);
    chk("dones_left", 32'(exp_done.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
